// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller: FSM states,
// parity encodings, entry width and the frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FRAME,
    ST_CAPTURE,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int DEFAULT_OSR = 16;
  localparam int ENTRY_W     = 10;

  // Bits on the line for one frame: start + data + optional parity + stop(s).
  function automatic logic [3:0] frame_bits(input logic snum, input logic dnum,
                                            input logic [1:0] par);
    logic [3:0] n;
    n = 4'd1 + (dnum ? 4'd7 : 4'd8)
        + (((par == PAR_ODD) || (par == PAR_EVEN)) ? 4'd1 : 4'd0)
        + (snum ? 4'd2 : 4'd1);
    return n;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Received-entry buffer: {parity_warn, frame_warn, data[7:0]}, power-of-2 depth.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q;
  logic               do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame timing FSM, format shadow/apply and result FIFO.
// Optional error counters are built when RXCTRL_ERRCNT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OSR        = DEFAULT_OSR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       RX_clk,
  input  logic       rst,
  input  logic       input_signal,
  input  logic       cfg_wr,
  input  logic       cfg_snum,
  input  logic       cfg_dnum,
  input  logic [1:0] cfg_par,
  output logic       snum,
  output logic       dnum,
  output logic [1:0] par,
  input  logic [7:0] rx_data,
  input  logic       rx_parity_warning,
  input  logic       rx_frame_warning,
  output logic [7:0] out_data,
  output logic [1:0] out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       cfg_pending,
  output logic       overflow
`ifdef RXCTRL_ERRCNT_EN
  ,
  input  logic       err_clr,
  output logic [7:0] par_err_cnt,
  output logic [7:0] frm_err_cnt
`endif
);

  localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);

  rx_state_e          state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [3:0]         bit_q, bit_d;
  logic               snum_q, dnum_q, sh_snum_q, sh_dnum_q, pend_q, overflow_q;
  logic [1:0]         par_q, sh_par_q;
  logic [3:0]         nbits;
  logic               push, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign nbits = frame_bits(snum_q, dnum_q, par_q);

  // bit_q doubles as the settle counter in CAPTURE, giving the receiver two cycles.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!input_signal) begin
          state_d = ST_START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TICK_HALF) begin
          if (input_signal) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else begin
            state_d = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if ((bit_q == nbits - 4'd1) && (tick_q == TICK_HALF)) begin
          state_d = ST_CAPTURE;
          tick_d  = '0;
          bit_d   = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          bit_d  = bit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (bit_q == 4'd2) begin
          push    = 1'b1;
          state_d = ST_WAIT_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (input_signal) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge RX_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      snum_q     <= 1'b1;
      dnum_q     <= 1'b0;
      par_q      <= PAR_NONE;
      sh_snum_q  <= 1'b0;
      sh_dnum_q  <= 1'b0;
      sh_par_q   <= PAR_NONE;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      overflow_q <= push && fifo_full && !out_ready;
      // Format only changes between frames; a write in the apply cycle stays pending.
      if ((state_q == ST_IDLE) && pend_q) begin
        snum_q <= sh_snum_q;
        dnum_q <= sh_dnum_q;
        par_q  <= sh_par_q;
      end
      if (cfg_wr) begin
        sh_snum_q <= cfg_snum;
        sh_dnum_q <= cfg_dnum;
        sh_par_q  <= cfg_par;
        pend_q    <= 1'b1;
      end else if (state_q == ST_IDLE) begin
        pend_q <= 1'b0;
      end
    end
  end

  rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (RX_clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .wdata ({rx_parity_warning, rx_frame_warning, rx_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_rdata[7:0];
  assign out_err     = fifo_rdata[9:8];
  assign busy        = (state_q != ST_IDLE);
  assign cfg_pending = pend_q;
  assign overflow    = overflow_q;
  assign snum        = snum_q;
  assign dnum        = dnum_q;
  assign par         = par_q;

`ifdef RXCTRL_ERRCNT_EN
  logic [7:0] par_cnt_q, frm_cnt_q;
  logic       push_ok;

  assign push_ok = push && (!fifo_full || out_ready);

  always_ff @(posedge RX_clk) begin
    if (rst || err_clr) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else if (push_ok) begin
      if (rx_parity_warning && (par_cnt_q != 8'hFF)) par_cnt_q <= par_cnt_q + 1'b1;
      if (rx_frame_warning && (frm_cnt_q != 8'hFF))  frm_cnt_q <= frm_cnt_q + 1'b1;
    end
  end

  assign par_err_cnt = par_cnt_q;
  assign frm_err_cnt = frm_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames are generated from the frame-format rules,
// the expected buffer contents and overflow count come from a queue model.
module tb_uart_rx_ctrl;

  localparam int OSR   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b1, input_signal = 1'b1;
  logic       cfg_wr = 1'b0, cfg_snum = 1'b0, cfg_dnum = 1'b0;
  logic [1:0] cfg_par = 2'b00;
  logic       snum, dnum;
  logic [1:0] par;
  logic [7:0] rx_data = 8'h00;
  logic       rx_parity_warning = 1'b0, rx_frame_warning = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_err;
  logic       out_valid, out_ready = 1'b0;
  logic       busy, cfg_pending, overflow;
`ifdef RXCTRL_ERRCNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] par_err_cnt, frm_err_cnt;
  int         m_pcnt = 0, m_fcnt = 0;
`endif

  int         vectors = 0, miscompares = 0, ovf_seen = 0, exp_ovf = 0;
  logic       m_snum = 1'b1, m_dnum = 1'b0;
  logic [1:0] m_par = 2'b00;
  logic [9:0] exp_q[$];

  uart_rx_ctrl #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .RX_clk(clk), .rst(rst), .input_signal(input_signal),
    .cfg_wr(cfg_wr), .cfg_snum(cfg_snum), .cfg_dnum(cfg_dnum), .cfg_par(cfg_par),
    .snum(snum), .dnum(dnum), .par(par),
    .rx_data(rx_data), .rx_parity_warning(rx_parity_warning), .rx_frame_warning(rx_frame_warning),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .cfg_pending(cfg_pending), .overflow(overflow)
`ifdef RXCTRL_ERRCNT_EN
    , .err_clr(err_clr), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow === 1'b1) ovf_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input logic s, input logic dn, input logic [1:0] p);
    return 1 + (dn ? 7 : 8) + ((p == 2'b01 || p == 2'b10) ? 1 : 0) + (s ? 2 : 1);
  endfunction

  // Cycle (counted from the edge that first sees the start bit) where out_valid shows
  // the entry: middle of last bit, two settle cycles, one push cycle, then visible.
  function automatic int exp_rise(input int n);
    return (n - 1) * OSR + OSR / 2 + 3;
  endfunction

  function automatic logic line_bit(input int b, input logic [7:0] d, input logic dn,
                                    input logic [1:0] p);
    int   nd;
    logic ones;
    nd   = dn ? 7 : 8;
    ones = 1'b0;
    for (int i = 0; i < nd; i++) ones = ones ^ d[i];
    if (b == 0) return 1'b0;
    if (b <= nd) return d[b-1];
    if (b == nd + 1 && p == 2'b01) return ~ones;
    if (b == nd + 1 && p == 2'b10) return ones;
    return 1'b1;
  endfunction

  task automatic model_push(input logic [9:0] e, input bit popped);
    if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(e);
`ifdef RXCTRL_ERRCNT_EN
      if (e[9] && m_pcnt < 255) m_pcnt++;
      if (e[8] && m_fcnt < 255) m_fcnt++;
`endif
    end else begin
      exp_ovf++;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pw, input logic fw,
                           input int pop_c, input int cfg_c, input logic [1:0] cfg_p,
                           output int rise_c, output logic [1:0] mid_par, output logic mid_pend);
    int   n;
    logic prev;
    n = frame_len(m_snum, m_dnum, m_par);
    rx_data = d; rx_parity_warning = pw; rx_frame_warning = fw;
    rise_c = -1; mid_par = 2'bxx; mid_pend = 1'bx;
    prev = out_valid;
    input_signal = 1'b0;
    for (int c = 0; c < n * OSR; c++) begin
      step(1);
      if (out_valid && !prev && rise_c < 0) rise_c = c;
      prev = out_valid;
      if (cfg_c >= 0 && c == cfg_c + 10) begin
        mid_par  = par;
        mid_pend = cfg_pending;
      end
      cfg_wr    = (cfg_c >= 0) && (c == cfg_c);
      cfg_snum  = m_snum; cfg_dnum = m_dnum; cfg_par = cfg_p;
      out_ready = (c == pop_c);
      input_signal = line_bit((c + 1) / OSR, d, m_dnum, m_par);
    end
    input_signal = 1'b1; out_ready = 1'b0; cfg_wr = 1'b0;
    step(2);
    model_push({pw, fw, d}, pop_c >= 0);
  endtask

  task automatic set_cfg(input logic s, input logic dn, input logic [1:0] p);
    cfg_snum = s; cfg_dnum = dn; cfg_par = p; cfg_wr = 1'b1;
    step(1);
    cfg_wr = 1'b0;
    chk("cfg_pending_set", 32'(cfg_pending), 1);
    step(1);
    m_snum = s; m_dnum = dn; m_par = p;
    chk("cfg_pending_clr", 32'(cfg_pending), 0);
    chk("cfg_fmt", 32'({snum, dnum, par}), 32'({m_snum, m_dnum, m_par}));
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_data", 32'(out_data), 32'(exp_q[0][7:0]));
      chk("drain_err", 32'(out_err), 32'(exp_q[0][9:8]));
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
    end
    chk("drain_empty", 32'(out_valid), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_err"}, 32'(out_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_pend"}, 32'(cfg_pending), 0);
    chk({tag, "_fmt"}, 32'({snum, dnum, par}), 32'(4'b1000));
  endtask

  initial begin
    int         rc, ov0;
    logic [1:0] mp;
    logic       mpend;

    rst = 1'b1;
    step(3);
    chk_reset("reset");
    rst = 1'b0;
    step(1);

    // 8N1 frame 0x55 with exact output timing
    set_cfg(1'b0, 1'b0, 2'b00);
    run_frame(8'h55, 1'b0, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    chk("8n1_rise_cycle", rc, 155);
    chk("8n1_data", 32'(out_data), 32'h55);
    chk("8n1_err", 32'(out_err), 0);
    drain();

    // false start: low for 5 cycles only
    input_signal = 1'b0;
    step(5);
    input_signal = 1'b1;
    step(3);
    chk("false_start_busy_c7", 32'(busy), 1);
    step(1);
    chk("false_start_busy_c8", 32'(busy), 0);
    step(4);
    chk("false_start_no_push", 32'(out_valid), 0);

    // overflow on the fifth unread frame
    ov0 = ovf_seen;
    for (int i = 0; i < 4; i++)
      run_frame(8'($urandom), 1'b0, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    chk("ovf_none_after_4", ovf_seen - ov0, 0);
    run_frame(8'hE7, 1'b0, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    chk("ovf_once_on_5", ovf_seen - ov0, 1);
    chk("ovf_model_count", ovf_seen, exp_ovf);
    drain();

    // push and pop in the same cycle on a full buffer
    for (int i = 0; i < 4; i++)
      run_frame(8'($urandom), 1'b0, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    ov0 = ovf_seen;
    run_frame(8'h5A, 1'b1, 1'b0, exp_rise(frame_len(m_snum, m_dnum, m_par)) - 1, -1, 2'b00,
              rc, mp, mpend);
    chk("full_pushpop_no_ovf", ovf_seen - ov0, 0);
    drain();

    // format write during a frame is held until the controller is idle
    run_frame(8'hA3, 1'b0, 1'b0, -1, 50, 2'b10, rc, mp, mpend);
    chk("midcfg_par_held", 32'(mp), 0);
    chk("midcfg_pending", 32'(mpend), 1);
    chk("midcfg_par_applied", 32'(par), 32'(2'b10));
    chk("midcfg_pending_clr", 32'(cfg_pending), 0);
    m_par = 2'b10;
    drain();

    // second write in the apply cycle stays pending
    cfg_snum = 1'b1; cfg_dnum = 1'b1; cfg_par = 2'b01; cfg_wr = 1'b1;
    step(1);
    cfg_snum = 1'b0; cfg_dnum = 1'b0; cfg_par = 2'b00;
    step(1);
    cfg_wr = 1'b0;
    chk("apply_win_fmt_first", 32'({snum, dnum, par}), 32'(4'b1101));
    chk("apply_win_pending", 32'(cfg_pending), 1);
    step(1);
    chk("apply_win_fmt_second", 32'({snum, dnum, par}), 0);
    chk("apply_win_pending_clr", 32'(cfg_pending), 0);
    m_snum = 1'b0; m_dnum = 1'b0; m_par = 2'b00;

    // frame warning from the receiver
`ifdef RXCTRL_ERRCNT_EN
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    m_pcnt = 0; m_fcnt = 0;
    chk("errclr_par", 32'(par_err_cnt), 0);
    chk("errclr_frm", 32'(frm_err_cnt), 0);
`endif
    run_frame(8'h3C, 1'b0, 1'b1, -1, -1, 2'b00, rc, mp, mpend);
    chk("frmwarn_err", 32'(out_err), 32'(2'b01));
    chk("frmwarn_data", 32'(out_data), 32'h3C);
`ifdef RXCTRL_ERRCNT_EN
    chk("frmwarn_cnt", 32'(frm_err_cnt), 1);
`endif
    drain();

    // random formats, data and warnings
    for (int i = 0; i < 8; i++) begin
      logic       s, dn, pw, fw;
      logic [1:0] p;
      logic [7:0] d;
      s  = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      p  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      pw = 1'($urandom_range(0, 1));
      fw = 1'($urandom_range(0, 1));
      set_cfg(s, dn, p);
      run_frame(d, pw, fw, -1, -1, 2'b00, rc, mp, mpend);
      chk("rand_rise_cycle", rc, exp_rise(frame_len(s, dn, p)));
      drain();
`ifdef RXCTRL_ERRCNT_EN
      chk("rand_par_cnt", 32'(par_err_cnt), m_pcnt);
      chk("rand_frm_cnt", 32'(frm_err_cnt), m_fcnt);
`endif
    end

    // reset in bit 4 of a frame with an entry buffered and a format pending
    set_cfg(1'b0, 1'b0, 2'b00);
    run_frame(8'h81, 1'b0, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    input_signal = 1'b0;
    step(10);
    cfg_par = 2'b01; cfg_wr = 1'b1;
    step(1);
    cfg_wr = 1'b0;
    step(61);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_pending", 32'(cfg_pending), 1);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    step(1);
    chk_reset("midframe_rst");
    rst = 1'b0;
    input_signal = 1'b1;
    exp_q.delete();
    m_snum = 1'b1; m_dnum = 1'b0; m_par = 2'b00;
`ifdef RXCTRL_ERRCNT_EN
    m_pcnt = 0; m_fcnt = 0;
`endif
    step(20);
    chk("post_rst_no_push", 32'(out_valid), 0);
    set_cfg(1'b0, 1'b0, 2'b00);
    run_frame(8'hC6, 1'b1, 1'b0, -1, -1, 2'b00, rc, mp, mpend);
    chk("post_rst_rise_cycle", rc, 155);
    chk("post_rst_err", 32'(out_err), 32'(2'b10));
    drain();

    chk("total_overflows", ovf_seen, exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
